// File: rtl/rob_complete_queue_pkg.sv
// Shared types and sizing for the FU->ROB completion queue.
package rob_complete_queue_pkg;

  localparam int unsigned ROB_IDX_W        = 5;
  localparam int unsigned XLEN             = 32;
  localparam int unsigned CQ_SZ            = 8;
  localparam int unsigned NUM_FU_DONE      = 4;
  localparam int unsigned FU_ROB_PACKET_SZ = 2;
  localparam int unsigned CQ_PTR_WIDTH     = $clog2(CQ_SZ);
  localparam int unsigned CQ_CNT_WIDTH     = $clog2(CQ_SZ + 1);

  typedef struct packed {
    logic                 executed;
    logic [ROB_IDX_W-1:0] robn;
    logic                 branch_taken;
    logic [XLEN-1:0]      target_addr;
  } FU_ROB_PACKET;

endpackage

// File: rtl/rob_complete_queue_prefix_rank.sv
// Exclusive prefix popcount: rank_o[i] = number of set valid_i bits below index i.
module prefix_rank #(
  parameter int unsigned N     = 4,
  parameter int unsigned RankW = $clog2(N + 1)
) (
  input  logic [N-1:0]            valid_i,
  output logic [N-1:0][RankW-1:0] rank_o
);

  always_comb begin
    logic [RankW-1:0] acc;
    acc    = '0;
    rank_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rank_o[i] = acc;
      acc       = acc + RankW'(valid_i[i]);
    end
  end

endmodule

// File: rtl/rob_complete_queue.sv
// Circular completion queue between FU writeback ports and the ROB; up to OUT_W reports per cycle.
module rob_complete_queue
  import rob_complete_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = CQ_SZ,
  parameter int unsigned NUM_FU = NUM_FU_DONE,
  parameter int unsigned OUT_W  = FU_ROB_PACKET_SZ
) (
  input  logic                             clock,
  input  logic                             reset,
  input  FU_ROB_PACKET [NUM_FU-1:0]        fu_done_packet,
  output logic         [NUM_FU-1:0]        fu_ready,
  input  logic                             squash,
  output FU_ROB_PACKET [OUT_W-1:0]         fu_rob_packet,
  output logic         [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned RankW = $clog2(NUM_FU + 1);

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  FU_ROB_PACKET    entries_q [DEPTH];
  FU_ROB_PACKET    entries_d [DEPTH];

  logic [NUM_FU-1:0]            fu_valid;
  logic [NUM_FU-1:0][RankW-1:0] rank;

  int unsigned cnt, drained, free_slots, accepted;

  always_comb begin
    fu_valid = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) fu_valid[i] = fu_done_packet[i].executed;
  end

  prefix_rank #(
    .N     (NUM_FU),
    .RankW (RankW)
  ) u_prefix_rank (
    .valid_i (fu_valid),
    .rank_o  (rank)
  );

  // Fill and drain; the drain term in free_slots lets a full queue accept in the same cycle.
  always_comb begin
    logic [PtrW-1:0] widx;
    cnt        = 32'(count_q);
    drained    = squash ? 0 : ((cnt < OUT_W) ? cnt : OUT_W);
    free_slots = DEPTH - cnt + drained;
    accepted   = 0;
    fu_ready   = '0;
    widx       = '0;
    for (int unsigned d = 0; d < DEPTH; d++) entries_d[d] = entries_q[d];
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = squash || (32'(rank[i]) < free_slots);
      if (fu_valid[i] && fu_ready[i] && !squash) begin
        widx            = PtrW'((32'(tail_q) + 32'(rank[i])) % DEPTH);
        entries_d[widx] = fu_done_packet[i];
        accepted        = accepted + 1;
      end
    end
    head_d  = PtrW'((32'(head_q) + drained) % DEPTH);
    tail_d  = PtrW'((32'(tail_q) + accepted) % DEPTH);
    count_d = CntW'(cnt - drained + accepted);
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    logic [PtrW-1:0] ridx;
    ridx          = '0;
    fu_rob_packet = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      if (!squash && (k < 32'(count_q))) begin
        ridx                      = PtrW'((32'(head_q) + k) % DEPTH);
        fu_rob_packet[k]          = entries_q[ridx];
        fu_rob_packet[k].executed = 1'b1;
      end
    end
  end

  assign occupancy = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) entries_q[d] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned d = 0; d < DEPTH; d++) entries_q[d] <= entries_d[d];
    end
  end

endmodule

// File: tb/tb_rob_complete_queue.sv
// Directed bench for rob_complete_queue with a small ordered scoreboard for the full/wrap phase.
module tb_rob_complete_queue;
  import rob_complete_queue_pkg::*;

  logic                          clock;
  logic                          reset;
  FU_ROB_PACKET [3:0]            fu_done_packet;
  logic         [3:0]            fu_ready;
  logic                          squash;
  FU_ROB_PACKET [1:0]            fu_rob_packet;
  logic         [3:0]            occupancy;

  int errors = 0;
  int checks = 0;

  rob_complete_queue #(
    .DEPTH  (8),
    .NUM_FU (4),
    .OUT_W  (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fu_done_packet (fu_done_packet),
    .fu_ready       (fu_ready),
    .squash         (squash),
    .fu_rob_packet  (fu_rob_packet),
    .occupancy      (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic FU_ROB_PACKET mk(input logic v, input logic [4:0] robn, input logic bt,
                                      input logic [31:0] tgt);
    FU_ROB_PACKET p;
    p.executed     = v;
    p.robn         = robn;
    p.branch_taken = bt;
    p.target_addr  = tgt;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  FU_ROB_PACKET sb[$];
  FU_ROB_PACKET exp_pkt;
  logic [4:0]   fu_robn [4];
  logic [4:0]   next_robn;
  logic [3:0]   vmask [8];
  logic [3:0]   exp_ready [8];
  logic [3:0]   exp_occ [8];
  int           occ_prev;

  initial begin
    reset          = 1'b1;
    squash         = 1'b0;
    fu_done_packet = '0;
    fu_done_packet[0] = mk(1'b1, 5'd9, 1'b0, 32'h10);
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_ready", 64'(fu_ready), 64'hf);
    check_eq("rst_slot0", 64'(fu_rob_packet[0].executed), 64'd0);
    check_eq("rst_slot1", 64'(fu_rob_packet[1].executed), 64'd0);
    check_eq("rst_occ", 64'(occupancy), 64'd0);
    reset          = 1'b0;
    fu_done_packet = '0;
    tick();
    check_eq("rst_nocapture", 64'(occupancy), 64'd0);

    // Single report from FU2
    fu_done_packet[2] = mk(1'b1, 5'd5, 1'b1, 32'h40);
    tick();
    fu_done_packet = '0;
    #1;
    check_eq("single_slot0", 64'(fu_rob_packet[0]), 64'(mk(1'b1, 5'd5, 1'b1, 32'h40)));
    check_eq("single_slot1", 64'(fu_rob_packet[1].executed), 64'd0);
    check_eq("single_occ", 64'(occupancy), 64'd1);
    tick();
    check_eq("single_drained", 64'(occupancy), 64'd0);

    // Burst from all four FUs
    for (int i = 0; i < 4; i++) fu_done_packet[i] = mk(1'b1, 5'(i + 1), 1'b0, 32'(i));
    #1;
    check_eq("burst_ready", 64'(fu_ready), 64'hf);
    tick();
    fu_done_packet = '0;
    #1;
    check_eq("burst_occ4", 64'(occupancy), 64'd4);
    check_eq("burst_s0a", 64'(fu_rob_packet[0].robn), 64'd1);
    check_eq("burst_s1a", 64'(fu_rob_packet[1].robn), 64'd2);
    tick();
    check_eq("burst_occ2", 64'(occupancy), 64'd2);
    check_eq("burst_s0b", 64'(fu_rob_packet[0].robn), 64'd3);
    check_eq("burst_s1b", 64'(fu_rob_packet[1].robn), 64'd4);
    tick();
    check_eq("burst_occ0", 64'(occupancy), 64'd0);

    // Fill to full, hold there across pointer wrap, last cycle only FU0/FU1 valid
    vmask     = '{4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'h3};
    exp_ready = '{4'hf, 4'hf, 4'hf, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
    exp_occ   = '{4'd4, 4'd6, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    for (int i = 0; i < 4; i++) fu_robn[i] = 5'(8 + i);
    next_robn = 5'd12;
    occ_prev  = 0;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++)
        fu_done_packet[i] = vmask[t][i] ? mk(1'b1, fu_robn[i], 1'(i & 1), 32'h100 + 32'(fu_robn[i]))
                                        : '0;
      #1;
      check_eq("full_ready", 64'(fu_ready), 64'(exp_ready[t]));
      for (int k = 0; k < 2; k++) begin
        if (k < occ_prev) begin
          exp_pkt = sb.pop_front();
          check_eq("full_slot", 64'(fu_rob_packet[k]), 64'(exp_pkt));
        end else begin
          check_eq("full_slot_idle", 64'(fu_rob_packet[k].executed), 64'd0);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (vmask[t][i] && exp_ready[t][i]) begin
          sb.push_back(fu_done_packet[i]);
          fu_robn[i] = next_robn;
          next_robn  = next_robn + 5'd1;
        end
      end
      tick();
      check_eq("full_occ", 64'(occupancy), 64'(exp_occ[t]));
      occ_prev = int'(exp_occ[t]);
    end

    // Drain one cycle to reach 6, then squash with FU1 valid
    fu_done_packet = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_pkt = sb.pop_front();
      check_eq("pre_squash_slot", 64'(fu_rob_packet[k]), 64'(exp_pkt));
    end
    tick();
    check_eq("pre_squash_occ", 64'(occupancy), 64'd6);
    fu_done_packet[1] = mk(1'b1, 5'd25, 1'b0, 32'h77);
    squash            = 1'b1;
    #1;
    check_eq("squash_ready", 64'(fu_ready), 64'hf);
    check_eq("squash_s0", 64'(fu_rob_packet[0].executed), 64'd0);
    check_eq("squash_s1", 64'(fu_rob_packet[1].executed), 64'd0);
    tick();
    squash         = 1'b0;
    fu_done_packet = '0;
    sb.delete();
    check_eq("squash_occ", 64'(occupancy), 64'd0);
    check_eq("squash_empty", 64'(fu_rob_packet[0].executed), 64'd0);

    // Post-squash: FU3 report is the only one present
    fu_done_packet[3] = mk(1'b1, 5'd21, 1'b1, 32'h200);
    tick();
    fu_done_packet = '0;
    #1;
    check_eq("post_sq_slot0", 64'(fu_rob_packet[0]), 64'(mk(1'b1, 5'd21, 1'b1, 32'h200)));
    check_eq("post_sq_slot1", 64'(fu_rob_packet[1].executed), 64'd0);
    check_eq("post_sq_occ", 64'(occupancy), 64'd1);

    // Reset mid-operation with traffic
    fu_done_packet[0] = mk(1'b1, 5'd30, 1'b0, 32'h5);
    reset             = 1'b1;
    tick();
    reset          = 1'b0;
    fu_done_packet = '0;
    #1;
    check_eq("midrst_occ", 64'(occupancy), 64'd0);
    check_eq("midrst_slot0", 64'(fu_rob_packet[0].executed), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
